// File: rtl/canvas_downsampler_if.sv
// Pixel stream from the canvas downsampler to the neural-net input loader.
//
// Handshake: a beat transfers on a rising clock edge where px_valid and
// px_ready are both high. While px_valid is high and px_ready is low, the
// source holds px_data and px_index stable and keeps px_valid high (except
// when a capture is aborted). px_ready may change freely and does not depend
// on px_valid.
interface canvas_downsampler_if;
    logic [7:0] px_data;
    logic [9:0] px_index;
    logic       px_valid;
    logic       px_ready;

    modport master (
        output px_data,
        output px_index,
        output px_valid,
        input  px_ready
    );

    modport slave (
        input  px_data,
        input  px_index,
        input  px_valid,
        output px_ready
    );
endinterface

// File: rtl/canvas_downsampler.sv
// Downsamples the 280x280 drawing canvas of the VGA raster into 28x28
// intensities. Each 10x10 block's ink count is accumulated while the raster
// passes through it. At the end of each block row the 28 counts are moved
// into an output buffer, which is then streamed out one column at a time.
module canvas_downsampler (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        pixel_en,
    input  logic [9:0]                  DrawX,
    input  logic [9:0]                  DrawY,
    input  logic                        ink,
    input  logic                        capture_req,
    canvas_downsampler_if.master        px,
    output logic                        busy,
    output logic                        done,
    output logic                        overrun,
    output logic [1:0]                  dbg_state
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FRAME = 2'd1,
        CAPTURE    = 2'd2,
        DONE       = 2'd3
    } state_t;

    state_t     state_q;
    state_t     state_d;

    // Per-column ink counters for the block row being scanned.
    logic [6:0] acc_q   [0:27];
    logic [6:0] acc_inc [0:27];
    // Completed block row awaiting streaming.
    logic [6:0] obuf_q  [0:27];
    logic       obuf_full_q;
    logic [4:0] obuf_row_q;
    logic [4:0] obuf_col_q;
    // Block row currently being accumulated; frame_done_q freezes capture
    // once row 27 has been handed to the buffer.
    logic [4:0] row_cnt_q;
    logic       frame_done_q;
    logic       overrun_q;

    logic [9:0] dx;
    logic [9:0] dy;
    logic [9:0] col_sel;
    logic [9:0] y_phase;
    logic       in_x;
    logic       in_y;
    logic       capture_active;
    logic       pix_inc;
    logic       row_end;
    logic       accept;
    logic       last_beat;
    logic       overrun_evt;
    logic [6:0] cur_cnt;

    // Raster decode, handshake events and accumulator increment values.
    always_comb begin
        dx             = DrawX - 10'd180;
        dy             = DrawY - 10'd100;
        col_sel        = dx / 10'd10;
        y_phase        = dy % 10'd10;
        in_x           = (DrawX >= 10'd180) && (DrawX <= 10'd459);
        in_y           = (DrawY >= 10'd100) && (DrawY <= 10'd379);
        capture_active = (state_q == CAPTURE) && !frame_done_q;
        pix_inc        = capture_active && pixel_en && in_x && in_y && ink;
        row_end        = capture_active && pixel_en && (DrawX == 10'd459) &&
                         in_y && (y_phase == 10'd9);
        accept         = obuf_full_q && px.px_ready;
        last_beat      = accept && (obuf_col_q == 5'd27);
        // Emptying the buffer on the very cycle of a row end is not an overrun.
        overrun_evt    = row_end && obuf_full_q && !last_beat;
        for (int i = 0; i < 28; i++) begin
            if (pix_inc && (col_sel == 10'(i))) begin
                acc_inc[i] = acc_q[i] + 7'd1;
            end else begin
                acc_inc[i] = acc_q[i];
            end
        end
    end

    // Next-state and status outputs of the capture FSM.
    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_req) begin
                    state_d = WAIT_FRAME;
                end
            end
            WAIT_FRAME: begin
                busy = 1'b1;
                if (pixel_en && (DrawX == 10'd0) && (DrawY == 10'd0)) begin
                    state_d = CAPTURE;
                end
            end
            CAPTURE: begin
                busy = 1'b1;
                if (overrun_evt) begin
                    state_d = IDLE;
                end else if (last_beat && (obuf_row_q == 5'd27)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register, accumulators, output buffer and sticky overrun flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= IDLE;
            obuf_full_q  <= 1'b0;
            obuf_row_q   <= 5'd0;
            obuf_col_q   <= 5'd0;
            row_cnt_q    <= 5'd0;
            frame_done_q <= 1'b0;
            overrun_q    <= 1'b0;
            for (int i = 0; i < 28; i++) begin
                acc_q[i]  <= 7'd0;
                obuf_q[i] <= 7'd0;
            end
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && capture_req) begin
                overrun_q    <= 1'b0;
                row_cnt_q    <= 5'd0;
                frame_done_q <= 1'b0;
                for (int i = 0; i < 28; i++) begin
                    acc_q[i] <= 7'd0;
                end
            end else begin
                if (accept) begin
                    if (obuf_col_q == 5'd27) begin
                        obuf_full_q <= 1'b0;
                        obuf_col_q  <= 5'd0;
                    end else begin
                        obuf_col_q  <= obuf_col_q + 5'd1;
                    end
                end
                if (overrun_evt) begin
                    overrun_q   <= 1'b1;
                    obuf_full_q <= 1'b0;
                    obuf_row_q  <= 5'd0;
                    obuf_col_q  <= 5'd0;
                    for (int i = 0; i < 28; i++) begin
                        acc_q[i]  <= 7'd0;
                        obuf_q[i] <= 7'd0;
                    end
                end else if (row_end) begin
                    obuf_full_q <= 1'b1;
                    obuf_row_q  <= row_cnt_q;
                    obuf_col_q  <= 5'd0;
                    row_cnt_q   <= row_cnt_q + 5'd1;
                    if (row_cnt_q == 5'd27) begin
                        frame_done_q <= 1'b1;
                    end
                    for (int i = 0; i < 28; i++) begin
                        obuf_q[i] <= acc_inc[i];
                        acc_q[i]  <= 7'd0;
                    end
                end else begin
                    for (int i = 0; i < 28; i++) begin
                        acc_q[i] <= acc_inc[i];
                    end
                end
            end
        end
    end

    // Intensity = 2.5 * count, truncated: 2*count + count/2.
    assign cur_cnt      = obuf_q[obuf_col_q];
    assign px.px_data   = {cur_cnt, 1'b0} + {2'b00, cur_cnt[6:1]};
    assign px.px_index  = ({5'd0, obuf_row_q} * 10'd28) + {5'd0, obuf_col_q};
    assign px.px_valid  = obuf_full_q;
    assign overrun      = overrun_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_canvas_downsampler.sv
// Directed bench for canvas_downsampler. Only the raster pixels that matter
// (frame start, inked pixels, block-row ends and a few outside-window inks)
// are strobed, so a whole frame costs a few thousand clocks.
module tb_canvas_downsampler;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       pixel_en;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       ink;
    logic       capture_req;
    logic       busy;
    logic       done;
    logic       overrun;
    logic [1:0] dbg_state;

    canvas_downsampler_if px_if ();

    canvas_downsampler dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pixel_en    (pixel_en),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .ink         (ink),
        .capture_req (capture_req),
        .px          (px_if),
        .busy        (busy),
        .done        (done),
        .overrun     (overrun),
        .dbg_state   (dbg_state)
    );

    // Clock: 50 MHz.
    always #10 Clk = ~Clk;

    int          n_checks   = 0;
    int          n_pass     = 0;
    int          ready_mode = 1;   // 0: never ready, 1: always ready, 2: random 75%
    logic [17:0] exp_q [$];
    logic [17:0] rx_q  [$];
    logic        rx_clear   = 1'b0;
    int          done_cnt   = 0;
    int          hold_err   = 0;
    logic        held_valid = 1'b0;
    logic [17:0] held_beat  = '0;

    // Records accepted beats, done pulses and stalls that change held data.
    always @(negedge Clk) begin
        if (rx_clear) begin
            rx_q.delete();
            done_cnt   = 0;
            hold_err   = 0;
            held_valid = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (held_valid && (px_if.px_valid === 1'b1) &&
                ({px_if.px_index, px_if.px_data} !== held_beat)) hold_err++;
            if ((px_if.px_valid === 1'b1) && (px_if.px_ready === 1'b1))
                rx_q.push_back({px_if.px_index, px_if.px_data});
            held_valid = (px_if.px_valid === 1'b1) && (px_if.px_ready !== 1'b1) && !Reset;
            held_beat  = {px_if.px_index, px_if.px_data};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // One clock: choose px_ready, then advance to just after the next edge.
    task automatic cycle();
        case (ready_mode)
            0:       px_if.px_ready = 1'b0;
            1:       px_if.px_ready = 1'b1;
            default: px_if.px_ready = ($urandom_range(0, 3) != 0);
        endcase
        @(posedge Clk);
        #1;
    endtask

    task automatic pix(input int x, input int y, input logic k);
        pixel_en = 1'b1;
        DrawX    = 10'(x);
        DrawY    = 10'(y);
        ink      = k;
        cycle();
        pixel_en = 1'b0;
        ink      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) cycle();
    endtask

    task automatic pulse_capture();
        capture_req = 1'b1;
        cycle();
        capture_req = 1'b0;
    endtask

    task automatic clear_rx();
        rx_clear = 1'b1;
        @(negedge Clk);
        #1;
        rx_clear = 1'b0;
    endtask

    // kind 0: blank; 1: block rows 0,1,27 fully inked plus inks just outside;
    // kind 2: 37 ink pixels in block (3,5).
    task automatic run_frame(input int kind, input int gap);
        pix(0, 0, 1'b0);
        pix(300, 99, 1'b1);
        for (int r = 0; r < 28; r++) begin
            int y0;
            y0 = 100 + 10 * r;
            if (kind == 1 && (r <= 1 || r == 27)) begin
                for (int ly = 0; ly < 10; ly++) begin
                    pix(179, y0 + ly, 1'b1);
                    for (int x = 180; x < 460; x++) pix(x, y0 + ly, 1'b1);
                    pix(460, y0 + ly, 1'b1);
                end
            end else begin
                if (kind == 2 && r == 3) begin
                    for (int k = 0; k < 37; k++) pix(230 + k % 10, 130 + k / 10, 1'b1);
                end
                pix(459, y0 + 9, 1'b0);
            end
            idle(gap);
        end
        pix(300, 380, 1'b1);
    endtask

    task automatic build_exp(input int kind);
        exp_q.delete();
        for (int i = 0; i < 784; i++) begin
            logic [7:0] d;
            d = 8'd0;
            if (kind == 1 && (i < 56 || i >= 756)) d = 8'd250;
            if (kind == 2 && i == 89) d = 8'd92;
            exp_q.push_back({10'(i), d});
        end
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n;
        n = 0;
        while (done_cnt == 0 && n < budget) begin
            cycle();
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic check_stream(input string tag);
        int bad;
        int first;
        bad   = 0;
        first = -1;
        check({tag, "_beats"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin
                if (first < 0) first = i;
                bad++;
            end
        end
        n_checks++;
        assert (bad == 0) n_pass++;
        else $error("FAIL %s_stream bad=%0d first=%0d observed=%h expected=%h",
                    tag, bad, first,
                    (first >= 0 && first < rx_q.size()) ? rx_q[first] : 18'h0,
                    exp_q[first]);
    endtask

    task automatic check_frame_end(input string tag);
        check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
        check({tag, "_overrun"},    32'(overrun),  32'd0);
        check({tag, "_busy"},       32'(busy),     32'd0);
        check({tag, "_state"},      32'(dbg_state), 32'(S_IDLE));
        check({tag, "_hold"},       32'(hold_err), 32'd0);
    endtask

    initial begin
        // Reset, with capture_req asserted alongside to show Reset wins.
        Reset          = 1'b1;
        pixel_en       = 1'b0;
        DrawX          = 10'd0;
        DrawY          = 10'd0;
        ink            = 1'b0;
        capture_req    = 1'b1;
        px_if.px_ready = 1'b1;
        idle(3);
        Reset       = 1'b0;
        capture_req = 1'b0;
        idle(1);
        check("rst_valid",   32'(px_if.px_valid), 32'd0);
        check("rst_data",    32'(px_if.px_data),  32'd0);
        check("rst_index",   32'(px_if.px_index), 32'd0);
        check("rst_busy",    32'(busy),           32'd0);
        check("rst_done",    32'(done),           32'd0);
        check("rst_overrun", 32'(overrun),        32'd0);
        check("rst_state",   32'(dbg_state),      32'(S_IDLE));

        // Blank canvas, requested mid-frame: the tail of the running frame is ignored.
        clear_rx();
        pulse_capture();
        check("blank_busy",  32'(busy),      32'd1);
        check("blank_state", 32'(dbg_state), 32'(S_WAIT));
        pix(300, 200, 1'b1);
        pix(459, 209, 1'b1);
        pix(459, 379, 1'b0);
        idle(3);
        check("wait_no_valid", 32'(px_if.px_valid), 32'd0);
        pulse_capture();
        check("wait_ignores_req", 32'(dbg_state), 32'(S_WAIT));
        build_exp(0);
        run_frame(0, 40);
        wait_done("blank", 200);
        check_stream("blank");
        check_frame_end("blank");

        // Full block rows 0, 1 and 27; ink just outside the window is ignored.
        clear_rx();
        build_exp(1);
        pulse_capture();
        run_frame(1, 40);
        wait_done("full", 200);
        check_stream("full");
        check_frame_end("full");

        // Single block (3,5) with 37 ink pixels, consumer always ready.
        clear_rx();
        build_exp(2);
        pulse_capture();
        run_frame(2, 40);
        wait_done("single", 200);
        check_stream("single");
        check_frame_end("single");

        // Same picture with a stalling consumer.
        clear_rx();
        ready_mode = 2;
        pulse_capture();
        run_frame(2, 100);
        wait_done("stall", 500);
        check_stream("stall");
        check_frame_end("stall");

        // Overrun: consumer never ready across two block-row ends.
        clear_rx();
        ready_mode = 0;
        pulse_capture();
        pix(0, 0, 1'b0);
        pix(459, 109, 1'b0);
        idle(2);
        check("ovr_first_valid", 32'(px_if.px_valid), 32'd1);
        check("ovr_first_index", 32'(px_if.px_index), 32'd0);
        pix(459, 119, 1'b0);
        check("ovr_flag",  32'(overrun),          32'd1);
        check("ovr_valid", 32'(px_if.px_valid),   32'd0);
        check("ovr_state", 32'(dbg_state),        32'(S_IDLE));
        check("ovr_busy",  32'(busy),             32'd0);
        idle(5);
        check("ovr_no_done", 32'(done_cnt), 32'd0);
        check("ovr_sticky",  32'(overrun),  32'd1);
        ready_mode = 1;
        pulse_capture();
        check("ovr_cleared", 32'(overrun),   32'd0);
        check("ovr_rearmed", 32'(dbg_state), 32'(S_WAIT));

        // Reset during block row 10 while row 9 is still streaming.
        clear_rx();
        pix(0, 0, 1'b0);
        for (int r = 0; r < 10; r++) begin
            pix(459, 109 + 10 * r, 1'b0);
            if (r < 9) idle(40);
        end
        idle(10);
        pix(200, 200, 1'b1);
        pix(201, 200, 1'b1);
        check("mid_valid", 32'(px_if.px_valid), 32'd1);
        check("mid_state", 32'(dbg_state),      32'(S_CAPTURE));
        Reset       = 1'b1;
        capture_req = 1'b1;
        cycle();
        Reset       = 1'b0;
        capture_req = 1'b0;
        check("mrst_valid",   32'(px_if.px_valid), 32'd0);
        check("mrst_data",    32'(px_if.px_data),  32'd0);
        check("mrst_index",   32'(px_if.px_index), 32'd0);
        check("mrst_busy",    32'(busy),           32'd0);
        check("mrst_overrun", 32'(overrun),        32'd0);
        check("mrst_state",   32'(dbg_state),      32'(S_IDLE));
        pix(459, 209, 1'b0);
        idle(30);
        check("mrst_still_idle", 32'(dbg_state),      32'(S_IDLE));
        check("mrst_no_valid",   32'(px_if.px_valid), 32'd0);
        check("mrst_no_done",    32'(done_cnt),       32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/canvas_downsampler.md
CANVAS_DOWNSAMPLER -- requirements
Module: canvas_downsampler

Interface
REQ-001 Clk  in  1  system clock, 50 MHz; the only clock; all logic on rising edge.
REQ-002 Reset  in  1  synchronous, active-high reset, sampled on rising Clk.
REQ-003 pixel_en  in  1  one-Clk strobe per VGA pixel (25 MHz rate); DrawX/DrawY/ink are valid only when high.
REQ-004 DrawX  in  10  current raster column, 0..799.
REQ-005 DrawY  in  10  current raster row, 0..524.
REQ-006 ink  in  1  1 = displayed pixel at (DrawX,DrawY) is drawn (stroke).
REQ-007 capture_req  in  1  single-cycle request to capture the next full frame.
REQ-008 px_data  out  8  downsampled intensity, 0..250.
REQ-009 px_index  out  10  linear NN input index, row*28+col, 0..783.
REQ-010 px_valid  out  1  px_data/px_index valid.
REQ-011 px_ready  in  1  consumer accepts when px_valid & px_ready in the same cycle.
REQ-012 busy  out  1  high in WAIT_FRAME and CAPTURE.
REQ-013 done  out  1  one-cycle pulse when all 784 values have been accepted.
REQ-014 overrun  out  1  sticky error flag; cleared by Reset or by an accepted capture_req.

Function
REQ-015 Canvas window: X 180..459, Y 100..379 (280x280); block (r,c) = 10x10 pixels at X=180+10c, Y=100+10r.
REQ-016 Block value: count = number of ink pixels in the block (0..100); px_data = 2*count + floor(count/2), 8-bit, no saturation required (max 250).
REQ-017 States: IDLE, WAIT_FRAME, CAPTURE, DONE.
REQ-018 IDLE: on capture_req -> WAIT_FRAME; clear overrun; clear all accumulators.
REQ-019 WAIT_FRAME: on pixel_en with DrawX=0, DrawY=0 -> CAPTURE; that pixel is processed in CAPTURE rules; a partial frame is never captured.
REQ-020 CAPTURE: on pixel_en inside the window with ink=1, increment accumulator acc[(DrawX-180)/10] (28 accumulators, 7-bit each); pixels outside the window are ignored.
REQ-021 Block-row end: on pixel_en at DrawX=459 with (DrawY-100) mod 10 = 9, copy all 28 values (after including the current pixel) into a 28-entry output buffer, tagged with row r, and clear the accumulators in the same cycle.
REQ-022 Streaming: buffer entries are emitted in column order 0..27; px_valid rises the cycle after the copy; px_data/px_index hold stable while px_valid & ~px_ready; next entry is presented the cycle after acceptance.
REQ-023 Overrun: if a block-row end occurs while the buffer still holds unaccepted entries -> set overrun, drop px_valid, clear the buffer, return to IDLE without a done pulse.
REQ-024 After entry 783 (r=27, c=27) is accepted -> DONE; DONE asserts done for one cycle -> IDLE.
REQ-025 capture_req is ignored outside IDLE.
REQ-026 busy = 1 in WAIT_FRAME and CAPTURE; busy = 0 in IDLE and DONE.
REQ-027 pixel_en low: no accumulator or raster-dependent state changes; the handshake still advances.

Reset
REQ-028 Reset has priority over all inputs, including capture_req.
REQ-029 Reset -> IDLE; px_valid=0, px_data=0, px_index=0, busy=0, done=0, overrun=0; accumulators and buffer cleared.
REQ-030 Reset mid-CAPTURE aborts with no done pulse; the first cycle after Reset deassertion behaves as IDLE.

Verification
REQ-031 Blank canvas (ink=0), px_ready=1, capture_req -> 784 beats, indices 0..783 in order, all px_data=0, one done pulse, overrun=0.
REQ-032 Full canvas (ink=1 inside the window only), px_ready=1 -> all px_data=250; ink set outside the window changes nothing.
REQ-033 Single block (r=3,c=5) with 37 ink pixels -> index 89 carries 92; all other indices carry 0.
REQ-034 px_ready toggled randomly (>=25% duty) -> data and indices identical to REQ-033; no overrun.
REQ-035 px_ready held low through two block-row ends -> overrun=1, px_valid=0, IDLE, no done; a following capture_req clears overrun.
REQ-036 capture_req mid-frame -> capture waits for (0,0); Reset asserted during row 10 -> all outputs at reset values, busy=0, no done.
